// File: rtl/ttt_pkg.sv
// ttt_pkg: cell encodings, scheduler state codes and board size shared by the move scheduler.
package ttt_pkg;
    localparam logic [1:0] CELL_EMPTY  = 2'b00;
    localparam logic [1:0] CELL_PLAYER = 2'b01;
    localparam logic [1:0] CELL_COMP   = 2'b10;
    localparam int NUM_CELLS = 9;
    typedef enum logic [5:0] {
        S_CLEAR = 6'b000001,
        S_WAIT  = 6'b000010,
        S_CHECK = 6'b000100,
        S_WRITE = 6'b001000,
        S_EVAL  = 6'b010000,
        S_DONE  = 6'b100000
    } state_t;
    function automatic logic addr_ok(input logic [3:0] a);
        return a != 4'd0 && a <= 4'(NUM_CELLS);
    endfunction
endpackage

// File: rtl/ttt_turn_timer.sv
// ttt_turn_timer: counts enabled cycles and flags expiry on the LIMIT-th one; LIMIT = 0 never expires.
module ttt_turn_timer #(
    parameter int LIMIT = 1000,
    parameter int TO_W  = 10
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_en,
    input  logic i_clr,
    output logic o_expire
);
    localparam logic [TO_W-1:0] LAST = TO_W'(LIMIT > 0 ? LIMIT - 1 : 0);
    logic [TO_W-1:0] r_cnt;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_cnt <= '0;
        else r_cnt <= i_clr ? '0 : i_en ? r_cnt + 1'b1 : r_cnt;
    end
    assign o_expire = (LIMIT > 0) && i_en && r_cnt == LAST;
endmodule

// File: rtl/ttt_move_sched.sv
// ttt_move_sched: alternates player/computer turns on the shared board write port and sequences clear, check, write and result evaluation.
module ttt_move_sched import ttt_pkg::*; #(
    parameter logic FIRST_MOVER  = 1'b1,
    parameter int   COMP_TIMEOUT = 1000,
    parameter int   TO_W         = 10
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       new_game,
    input  logic       player_req,
    input  logic [3:0] player_addr,
    output logic       player_ack,
    input  logic       computer_req,
    input  logic [3:0] computer_addr,
    output logic       computer_ack,
    output logic       ack_err,
    output logic [3:0] board_rd_addr,
    input  logic [1:0] board_rd_data,
    output logic       board_wr_en,
    output logic [3:0] board_wr_addr,
    output logic [1:0] board_wr_data,
    input  logic       result_valid,
    input  logic       result_win,
    input  logic       result_winner,
    input  logic       result_draw,
    output logic       turn,
    output logic       illegal_move,
    output logic [3:0] move_cnt,
    output logic       game_over,
    output logic       win,
    output logic       winner,
    output logic       draw
);
    state_t r_state;
    logic [3:0] r_clr_cnt, r_addr_q, r_wr_addr, r_move_cnt;
    logic [1:0] r_wr_data;
    logic r_wr_en, r_pack, r_cack, r_ack_err, r_turn, r_illegal, r_win, r_winner, r_draw;
    logic w_on_req, w_off_req, w_busy, w_reject, w_to_en, w_expire, w_sup;
    logic [3:0] w_on_addr;

    assign w_on_req  = r_turn ? player_req : computer_req;
    assign w_off_req = r_turn ? computer_req : player_req;
    assign w_on_addr = r_turn ? player_addr : computer_addr;
    // a rejected requester still holds req while its ack is showing; skip it for that cycle
    assign w_busy    = r_pack | r_cack;
    assign w_reject  = !addr_ok(r_addr_q) || board_rd_data != CELL_EMPTY;
    assign w_to_en   = r_state == S_WAIT && !r_turn;
    assign w_sup     = new_game && r_state == S_WRITE;

    ttt_turn_timer #(.LIMIT(COMP_TIMEOUT), .TO_W(TO_W)) u_timer (
        .clk(clk), .rstn(rstn), .i_en(w_to_en), .i_clr(!w_to_en), .o_expire(w_expire)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_CLEAR;
            r_clr_cnt <= 4'd1;
            r_addr_q <= '0;
            r_wr_addr <= '0;
            r_wr_data <= CELL_EMPTY;
            r_wr_en <= 1'b0;
            r_pack <= 1'b0;
            r_cack <= 1'b0;
            r_ack_err <= 1'b0;
            r_illegal <= 1'b0;
            r_turn <= FIRST_MOVER;
            r_move_cnt <= '0;
            r_win <= 1'b0;
            r_winner <= 1'b0;
            r_draw <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            r_pack <= 1'b0;
            r_cack <= 1'b0;
            r_ack_err <= 1'b0;
            r_illegal <= 1'b0;
            if (new_game) begin
                r_state <= S_CLEAR;
                r_clr_cnt <= 4'd1;
                r_turn <= FIRST_MOVER;
                r_move_cnt <= '0;
                r_win <= 1'b0;
                r_winner <= 1'b0;
                r_draw <= 1'b0;
            end else begin
                case (r_state)
                    S_CLEAR: begin
                        r_wr_en <= 1'b1;
                        r_wr_addr <= r_clr_cnt;
                        r_wr_data <= CELL_EMPTY;
                        r_clr_cnt <= r_clr_cnt + 4'd1;
                        if (r_clr_cnt == 4'(NUM_CELLS)) r_state <= S_WAIT;
                    end
                    S_WAIT: begin
                        r_illegal <= w_off_req;
                        if (w_on_req && !w_busy) begin
                            r_addr_q <= w_on_addr;
                            r_state <= S_CHECK;
                        end else if (w_expire) begin
                            r_win <= 1'b1;
                            r_winner <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                    S_CHECK: begin
                        r_pack <= r_turn;
                        r_cack <= !r_turn;
                        if (w_reject) begin
                            r_ack_err <= 1'b1;
                            r_illegal <= 1'b1;
                            r_state <= S_WAIT;
                        end else begin
                            r_wr_en <= 1'b1;
                            r_wr_addr <= r_addr_q;
                            r_wr_data <= r_turn ? CELL_PLAYER : CELL_COMP;
                            r_move_cnt <= r_move_cnt + 4'd1;
                            r_state <= S_WRITE;
                        end
                    end
                    S_WRITE: r_state <= S_EVAL;
                    S_EVAL: begin
                        if (result_valid) begin
                            if (result_win) begin
                                r_win <= 1'b1;
                                r_winner <= result_winner;
                                r_state <= S_DONE;
                            end else if (result_draw) begin
                                r_draw <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                r_turn <= !r_turn;
                                r_state <= S_WAIT;
                            end
                        end
                    end
                    S_DONE: r_state <= S_DONE;
                    default: r_state <= S_CLEAR;
                endcase
            end
        end
    end

    assign player_ack    = r_pack && !w_sup;
    assign computer_ack  = r_cack && !w_sup;
    assign ack_err       = r_ack_err;
    assign board_rd_addr = r_addr_q;
    assign board_wr_en   = r_wr_en;
    assign board_wr_addr = r_wr_addr;
    assign board_wr_data = r_wr_data;
    assign turn          = r_turn;
    assign illegal_move  = r_illegal;
    assign move_cnt      = r_move_cnt;
    assign game_over     = r_state == S_DONE;
    assign win           = r_win;
    assign winner        = r_winner;
    assign draw          = r_draw;
endmodule

// File: tb/tb_ttt_move_sched.sv
// tb_ttt_move_sched: directed move sequences against a turn/board model checked every cycle, plus literal spot checks.
module tb_ttt_move_sched;
    logic clk = 1'b0, rstn = 1'b1, new_game = 1'b0;
    logic player_req = 1'b0, computer_req = 1'b0;
    logic [3:0] player_addr = '0, computer_addr = '0;
    logic result_valid = 1'b0, result_win = 1'b0, result_winner = 1'b0, result_draw = 1'b0;
    logic player_ack, computer_ack, ack_err, board_wr_en, turn, illegal_move, game_over, win, winner, draw;
    logic [3:0] board_rd_addr, board_wr_addr, move_cnt;
    logic [1:0] board_rd_data, board_wr_data;
    logic [1:0] bmem [16] = '{2'b00, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11,
                              2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    logic [1:0] m_board [16];
    int n_tests = 0, n_fail = 0;
    bit chk_en = 1'b0;
    bit m_turn, m_win, m_winner, m_draw, m_over, m_pack, m_cack, m_err, m_ill, m_wen, m_rdv;
    logic [3:0] m_waddr, m_rda;
    logic [1:0] m_wdata;
    int m_cnt;

    ttt_move_sched #(.FIRST_MOVER(1'b1), .COMP_TIMEOUT(8), .TO_W(4)) dut (
        .clk(clk), .rstn(rstn), .new_game(new_game),
        .player_req(player_req), .player_addr(player_addr), .player_ack(player_ack),
        .computer_req(computer_req), .computer_addr(computer_addr), .computer_ack(computer_ack),
        .ack_err(ack_err), .board_rd_addr(board_rd_addr), .board_rd_data(board_rd_data),
        .board_wr_en(board_wr_en), .board_wr_addr(board_wr_addr), .board_wr_data(board_wr_data),
        .result_valid(result_valid), .result_win(result_win), .result_winner(result_winner),
        .result_draw(result_draw), .turn(turn), .illegal_move(illegal_move), .move_cnt(move_cnt),
        .game_over(game_over), .win(win), .winner(winner), .draw(draw)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (board_wr_en) bmem[board_wr_addr] <= board_wr_data;
    assign board_rd_data = bmem[board_rd_addr];

    task automatic chk(input string n, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, got, exp, $time);
        end
    endtask

    always @(negedge clk) if (chk_en) begin
        chk("turn", 8'(turn), 8'(m_turn));
        chk("move_cnt", 8'(move_cnt), 8'(m_cnt));
        chk("win", 8'(win), 8'(m_win));
        chk("winner", 8'(winner), 8'(m_winner));
        chk("draw", 8'(draw), 8'(m_draw));
        chk("game_over", 8'(game_over), 8'(m_over));
        chk("player_ack", 8'(player_ack), 8'(m_pack));
        chk("computer_ack", 8'(computer_ack), 8'(m_cack));
        if (m_pack || m_cack) chk("ack_err", 8'(ack_err), 8'(m_err));
        chk("illegal_move", 8'(illegal_move), 8'(m_ill));
        chk("wr_en", 8'(board_wr_en), 8'(m_wen));
        if (m_wen) begin
            chk("wr_addr", 8'(board_wr_addr), 8'(m_waddr));
            chk("wr_data", 8'(board_wr_data), 8'(m_wdata));
        end
        if (m_rdv) chk("rd_addr", 8'(board_rd_addr), 8'(m_rda));
        for (int i = 0; i < 16; i++) chk($sformatf("board[%0d]", i), 8'(bmem[i]), 8'(m_board[i]));
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (m_wen) m_board[m_waddr] = m_wdata;
        m_pack = 0; m_cack = 0; m_err = 0; m_ill = 0; m_wen = 0; m_rdv = 0;
    endtask

    task automatic reset_model();
        m_turn = 1'b1; m_cnt = 0; m_win = 0; m_winner = 0; m_draw = 0; m_over = 0;
    endtask

    task automatic run_clear();
        for (int k = 1; k <= 9; k++) begin
            tick();
            m_wen = 1; m_waddr = 4'(k); m_wdata = 2'b00;
        end
        tick();
    endtask

    task automatic restart();
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        reset_model();
        run_clear();
    endtask

    task automatic set_req(input bit side, input bit v, input logic [3:0] a);
        if (side) begin player_req = v; player_addr = a; end
        else begin computer_req = v; computer_addr = a; end
    endtask

    // starts in a WAIT cycle with side on turn; abort_at 2 = new_game in WRITE, 3 = new_game in EVAL
    task automatic do_move(input bit side, input logic [3:0] a, input bit both, input int abort_at,
                           input bit rw, input bit rwn, input bit rd);
        bit legal;
        legal = a >= 4'd1 && a <= 4'd9 && m_board[a] == 2'b00;
        set_req(side, 1'b1, a);
        if (both) set_req(!side, 1'b1, 4'd7);
        tick();
        m_rdv = 1; m_rda = a;
        if (both) begin m_ill = 1; set_req(!side, 1'b0, 4'd0); end
        tick();
        if (legal) begin
            m_wen = 1; m_waddr = a; m_wdata = side ? 2'b01 : 2'b10; m_cnt++;
            if (abort_at == 2) begin set_req(side, 1'b0, 4'd0); restart(); return; end
        end else begin
            m_err = 1; m_ill = 1;
        end
        if (side) m_pack = 1; else m_cack = 1;
        tick();
        set_req(side, 1'b0, 4'd0);
        if (!legal) return;
        if (abort_at == 3) begin restart(); return; end
        result_valid = 1; result_win = rw; result_winner = rwn; result_draw = rd;
        tick();
        result_valid = 0; result_win = 0; result_winner = 0; result_draw = 0;
        if (rw) begin m_win = 1; m_winner = rwn; m_over = 1; end
        else if (rd) begin m_draw = 1; m_over = 1; end
        else m_turn = !m_turn;
    endtask

    task automatic off_turn(input bit side, input int n);
        set_req(side, 1'b1, 4'd9);
        for (int i = 1; i <= n; i++) begin
            tick();
            m_ill = 1;
            if (i == n) set_req(side, 1'b0, 4'd0);
        end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) m_board[i] = (i >= 1 && i <= 9) ? 2'b11 : 2'b00;
        reset_model();
        {m_pack, m_cack, m_err, m_ill, m_wen, m_rdv} = '0;
        m_waddr = '0; m_wdata = '0; m_rda = '0;
        #2 rstn = 1'b0;
        chk_en = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstn = 1'b1;
        run_clear();
        chk("lit_turn_after_clear", 8'(turn), 8'd1);
        chk("lit_cnt_after_clear", 8'(move_cnt), 8'd0);
        do_move(1'b1, 4'd5, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        chk("lit_cnt_first_move", 8'(move_cnt), 8'd1);
        chk("lit_turn_first_move", 8'(turn), 8'd0);
        do_move(1'b0, 4'd5, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        off_turn(1'b1, 2);
        do_move(1'b0, 4'd1, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        do_move(1'b1, 4'd0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        do_move(1'b1, 4'd12, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        do_move(1'b1, 4'd3, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        do_move(1'b0, 4'd2, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        do_move(1'b1, 4'd7, 1'b0, 0, 1'b1, 1'b1, 1'b0);
        chk("lit_over_after_win", 8'(game_over), 8'd1);
        chk("lit_cnt_after_win", 8'(move_cnt), 8'd5);
        chk("lit_winner_after_win", 8'(winner), 8'd1);
        set_req(1'b1, 1'b1, 4'd4);
        set_req(1'b0, 1'b1, 4'd6);
        repeat (3) tick();
        set_req(1'b1, 1'b0, 4'd0);
        set_req(1'b0, 1'b0, 4'd0);
        restart();
        do_move(1'b1, 4'd5, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        repeat (7) tick();
        chk("lit_not_over_before_timeout", 8'(game_over), 8'd0);
        tick();
        m_win = 1; m_winner = 1; m_over = 1;
        chk("lit_over_timeout", 8'(game_over), 8'd1);
        chk("lit_win_timeout", 8'(win), 8'd1);
        chk("lit_winner_timeout", 8'(winner), 8'd1);
        restart();
        do_move(1'b1, 4'd1, 1'b0, 3, 1'b0, 1'b0, 1'b0);
        chk("lit_cnt_after_eval_abort", 8'(move_cnt), 8'd0);
        chk("lit_turn_after_eval_abort", 8'(turn), 8'd1);
        do_move(1'b1, 4'd2, 1'b0, 2, 1'b0, 1'b0, 1'b0);
        do_move(1'b1, 4'd4, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        chk("lit_draw", 8'(draw), 8'd1);
        chk("lit_win_on_draw", 8'(win), 8'd0);
        tick();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
